// File: rtl/blink_pattern_gen.sv
// Blink pattern generator: prescaled tick counter plus an FSM that plays a latched pattern on `on`.
// Latency: start -> on valid 1 cycle; all outputs registered. Optional looping pass via PATTERN_REPEAT_EN.
// Backpressure: none; start is sampled only in IDLE, stop only in PLAY, pattern is shadowed while busy.
module blink_pattern_gen #(
    parameter int TICK_DIV    = 10_000,
    parameter int SLOT_TICKS  = 1_000,
    parameter int PATTERN_LEN = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PATTERN_LEN-1:0] pattern,
    output logic [31:0]            counter,
    output logic                   on,
    output logic                   busy,
    output logic                   done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int IW = $clog2(PATTERN_LEN);

    typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;

    state_t                 state;
    logic [PW-1:0]          pre_cnt;
    logic [SW-1:0]          slot_cnt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_nxt;
    logic [PATTERN_LEN-1:0] shadow;
    logic                   tick;
    logic                   last_slot;
    logic                   last_idx;

    assign tick      = (pre_cnt == PW'(TICK_DIV - 1));
    assign last_slot = (slot_cnt == SW'(SLOT_TICKS - 1));
    assign last_idx  = (idx == IW'(PATTERN_LEN - 1));
    assign idx_nxt   = idx + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            slot_cnt <= '0;
            idx      <= '0;
            shadow   <= '0;
            counter  <= '0;
            on       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (tick) begin
                counter <= counter + 32'd1;
            end
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        shadow   <= pattern;
                        idx      <= '0;
                        slot_cnt <= '0;
                        // Restarting the prescaler makes the first slot full length.
                        pre_cnt  <= '0;
                        on       <= pattern[0];
                        busy     <= 1'b1;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    done <= 1'b0;
                    if (stop) begin
                        on    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick) begin
                        if (last_slot) begin
                            slot_cnt <= '0;
                            if (last_idx) begin
                                done <= 1'b1;
`ifdef PATTERN_REPEAT_EN
                                shadow <= pattern;
                                idx    <= '0;
                                on     <= pattern[0];
`else
                                on     <= 1'b0;
                                state  <= FINISH;
`endif
                            end else begin
                                idx <= idx_nxt;
                                on  <= shadow[idx_nxt];
                            end
                        end else begin
                            slot_cnt <= slot_cnt + SW'(1);
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    on    <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blink_pattern_gen.sv
// Bench for blink_pattern_gen: vector table of passes checked cycle by cycle through a scoreboard queue.
module tb_blink_pattern_gen;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int PL = 4;
    localparam int NONE = 99;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PL-1:0] pattern = '0;
    logic [31:0]   counter;
    logic          on, busy, done;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic on;
        logic busy;
        logic done;
    } obs_t;

    typedef struct {
        logic [PL-1:0] pat;
        int            stop_at;
        bit            perturb;
        bit            exp_done;
    } vec_t;

    obs_t q[$];
    vec_t vecs[6];

    blink_pattern_gen #(.TICK_DIV(TD), .SLOT_TICKS(ST), .PATTERN_LEN(PL)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pattern(pattern),
        .counter(counter), .on(on), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Expected observation k edges after the start edge of a one-shot pass.
    function automatic obs_t model_oneshot(input logic [PL-1:0] pat, input int stop_at, input int k);
        obs_t o;
        if (stop_at >= 1 && k >= stop_at) o = '{1'b0, 1'b0, 1'b0};
        else if (k < PL * ST * TD)        o = '{pat[k / (ST * TD)], 1'b1, 1'b0};
        else if (k == PL * ST * TD)       o = '{1'b0, 1'b1, 1'b1};
        else                              o = '{1'b0, 1'b0, 1'b0};
        return o;
    endfunction

    task automatic run_vec(input vec_t v, input int vi);
        int   nk;
        bit   saw_done;
        logic [31:0] c0;
        obs_t exp;
        nk = PL * ST * TD + 2;
        saw_done = 0;
        for (int k = 0; k < nk; k++) q.push_back(model_oneshot(v.pat, v.stop_at, k));
        pattern = v.pat;
        start = 1'b1;
        c0 = '0;
        for (int k = 0; k < nk; k++) begin
            if (k == 1) start = 1'b0;
            stop = (k == v.stop_at);
            if (v.perturb && k == 10) begin
                start = 1'b1;
                pattern = 4'b1111;
            end
            if (v.perturb && k == 11) start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k == 0) c0 = counter;
            if (done) saw_done = 1;
            exp = q.pop_front();
            chk($sformatf("vec%0d k%0d on/busy/done", vi, k), {32'd0, on, busy, done}, {32'd0, exp});
        end
        stop = 1'b0;
        chk($sformatf("vec%0d done_seen", vi), {34'd0, saw_done}, {34'd0, v.exp_done});
        chk($sformatf("vec%0d counter_delta", vi), {3'd0, counter - c0}, {3'd0, 32'(PL * ST)});
    endtask

`ifdef PATTERN_REPEAT_EN
    task automatic run_repeat();
        localparam int PASS = PL * ST * TD;
        logic [PL-1:0] p;
        obs_t exp;
        int stop_k;
        stop_k = 2 * PASS + 2;
        for (int k = 0; k <= stop_k + 1; k++) begin
            if (k >= stop_k)                 exp = '{1'b0, 1'b0, 1'b0};
            else begin
                p = (k < PASS) ? 4'b0011 : 4'b1000;
                exp = '{p[(k % PASS) / (ST * TD)], 1'b1, (k == PASS || k == 2 * PASS)};
            end
            q.push_back(exp);
        end
        pattern = 4'b0011;
        start = 1'b1;
        for (int k = 0; k <= stop_k + 1; k++) begin
            if (k == 1) start = 1'b0;
            if (k == 5) pattern = 4'b1000;
            stop = (k == stop_k);
            @(posedge clk);
            @(negedge clk);
            exp = q.pop_front();
            chk($sformatf("repeat k%0d on/busy/done", k), {32'd0, on, busy, done}, {32'd0, exp});
        end
        stop = 1'b0;
    endtask
`endif

    initial begin
        bit got;
        bit saw;
        vecs[0] = '{4'b0101, NONE, 1'b0, 1'b1};
        vecs[1] = '{4'b0101, NONE, 1'b1, 1'b1};
        vecs[2] = '{4'b1010, 12,   1'b0, 1'b0};
        vecs[3] = '{4'b1111, 32,   1'b0, 1'b0};
        vecs[4] = '{4'b0110, 0,    1'b0, 1'b1};
        vecs[5] = '{4'b1001, NONE, 1'b0, 1'b1};

        @(negedge clk);
        cyc(3);
        chk("reset_outputs", {counter, on, busy, done}, 35'd0);
        reset = 1'b0;
        cyc(3);
        chk("counter_before_first_tick", {3'd0, counter}, 35'd0);
        cyc(1);
        chk("counter_after_4", {3'd0, counter}, 35'd1);
        cyc(4);
        chk("counter_after_8", {3'd0, counter}, 35'd2);

`ifdef PATTERN_REPEAT_EN
        run_repeat();
`else
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
`endif

        // Counter wrap from all-ones.
        force dut.counter = 32'hFFFF_FFFF;
        #1;
        release dut.counter;
        got = 0;
        for (int i = 0; i < 2 * TD && !got; i++) begin
            cyc(1);
            if (counter != 32'hFFFF_FFFF) got = 1;
        end
        chk("counter_wrap_seen", {34'd0, got}, 35'd1);
        chk("counter_wrap_value", {2'd0, $isunknown(counter), counter}, 35'd0);

        // Reset in the middle of a pass.
        pattern = 4'b1111;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(9);
        chk("busy_before_reset", {34'd0, busy}, 35'd1);
        reset = 1'b1;
        cyc(1);
        chk("reset_midplay", {counter, on, busy, done}, 35'd0);
        reset = 1'b0;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (done || busy || on) saw = 1;
        end
        chk("no_activity_after_reset", {34'd0, saw}, 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
